d8m_pixel_source: RTL and testbench
===================================

// Module: d8m_pixel_source
// PURPOSE
//  Transmit side of the D8M parallel pixel interface (PIXEL_HS/VS/D[9:0]). Generates
//  synthetic Bayer RAW10 frames with the timing the SDRAM write port consumes
//  (valid = HS & VS). Stands in for the camera during bring-up and bench runs.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line
//  H_BLANK    160  HS-low clocks after each active line
//  V_LEAD     2    blank lines (VS high, HS low) before first active line
//  V_ACTIVE   480  active lines per frame
//  V_GAP      20   lines with VS low between frames
// PORTS
//  iCLK         in   1   pixel clock
//  iRST         in   1   synchronous reset, active-high
//  iEN          in   1   run enable, sampled at frame boundaries only
//  iPATTERN     in   2   pattern select, latched at frame start
//  oPIXEL_VS    out  1   frame valid, high for whole frame incl. lead lines
//  oPIXEL_HS    out  1   line valid, high during active pixels only
//  oPIXEL_D     out  10  RAW10 pixel, 0 whenever HS low
//  oFRAME_CNT   out  16  completed frames, wraps FFFF->0000
//  oFRAME_DONE  out  1   one-clock pulse on last active pixel of frame
// BEHAVIOUR
//  - All outputs registered; reset: VS=HS=DONE=0, D=0, FRAME_CNT=0, state IDLE.
//  - Line length H_TOTAL = H_ACTIVE+H_BLANK clocks; counters x (H_TOTAL range),
//    y (line index), wrap at their terminal count.
//  - FSM: IDLE -> LEAD when iEN=1 (VS rises next clock); LEAD: V_LEAD*H_TOTAL
//    clocks VS=1,HS=0 -> ACTIVE; ACTIVE: H_ACTIVE clocks HS=1 -> HBLANK;
//    HBLANK: H_BLANK clocks -> ACTIVE if y<V_ACTIVE-1 else GAP; GAP: VS=0 for
//    V_GAP*H_TOTAL clocks -> LEAD if iEN else IDLE. V_LEAD=0 goes straight to ACTIVE.
//  - iEN dropped mid-frame: current frame completes in full, then IDLE.
//  - oFRAME_DONE and FRAME_CNT increment coincide with last ACTIVE pixel of y=V_ACTIVE-1.
//  - Patterns (x = pixel index in line, y = active line index, both from 0):
//    0 horizontal ramp D = x[9:0]; 1 vertical ramp D = y[9:0];
//    2 Bayer RGGB fixed colour: (y0,x0)=00 ->3FF, 01/10 ->200, 11 ->000;
//    3 see CONFIGURATION.
//  - iPATTERN changes mid-frame have no effect until next frame start.
//  - Synchronous iRST mid-frame: outputs reset on next edge, no partial DONE pulse.
// CONFIGURATION
//  - D8M_SRC_PRBS_EN defined: pattern 3 = PRBS-10 (x^10+x^7+1), seed 10'h3FF at
//    each frame start, advances once per active pixel, D = LFSR state.
//  - Not defined: pattern 3 = FRAME_CNT[9:0] constant across the frame; no LFSR.
// STRUCTURE
//  - Package d8m_src_pkg: state enum (IDLE, LEAD, ACTIVE, HBLANK, GAP), pattern
//    codes PAT_HRAMP/PAT_VRAMP/PAT_BAYER/PAT_AUX, PRBS seed and tap constants.
//  - Sub-module d8m_src_pattern: pattern mux + optional LFSR, inputs x, y,
//    pattern, frame_cnt, advance, restart; one-cycle registered output aligned to HS.
//  - Top holds FSM, x/y counters, frame counter, output registers.
// TESTING  (bench params H_ACTIVE=8 H_BLANK=4 V_LEAD=1 V_ACTIVE=4 V_GAP=2)
//  - Reset, iEN=0 for 100 clocks -> VS=HS=0, D=0, FRAME_CNT=0 throughout.
//  - iEN=1, pattern 0 -> VS high 12 clocks before first HS; 4 HS bursts of 8
//    clocks, D=0..7 each; 4 blank clocks between; VS low 24 clocks; DONE once.
//  - Pattern 2 -> line 0: 3FF,200,3FF,200...; line 1: 200,000,200,000...
//  - iEN dropped during line 2 -> frame finishes (32 valid pixels), FRAME_CNT=1,
//    VS stays low afterwards.
//  - iRST during ACTIVE -> next clock all outputs 0, FRAME_CNT=0, no DONE pulse.
//  - Pattern 3 with D8M_SRC_PRBS_EN -> first pixels 3FF, 1FF (ref model match),
//    identical sequence every frame; without macro -> D=frame index each frame.

Source files
------------

// File: rtl/d8m_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d8m_src_pkg
// Purpose  : Shared types and constants for the D8M synthetic pixel source:
//            FSM state encoding, pattern select codes, PRBS-10 seed/taps and
//            the LFSR step function.
// Ports    : none (package)
// Options  : D8M_SRC_PRBS_EN selects the PRBS-10 auxiliary pattern
// Revision : 1.0 - initial release
// ============================================================================
package d8m_src_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        GAP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_BAYER = 2'd2,
        PAT_AUX   = 2'd3
    } pattern_t;

    // Bayer RGGB fixed-colour levels
    localparam logic [9:0] BAYER_R = 10'h3FF;
    localparam logic [9:0] BAYER_G = 10'h200;
    localparam logic [9:0] BAYER_B = 10'h000;

    // PRBS-10, x^10 + x^7 + 1. Bit 0 holds the oldest sample; the x^10 term
    // taps bit 0 and the x^7 term taps bit 3, feedback enters at bit 9.
    localparam logic [9:0] PRBS_SEED   = 10'h3FF;
    localparam int         PRBS_TAP_LO = 0;
    localparam int         PRBS_TAP_HI = 3;

    function automatic logic [9:0] prbs_next(input logic [9:0] s);
        return {s[PRBS_TAP_LO] ^ s[PRBS_TAP_HI], s[9:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/d8m_src_if.sv
`default_nettype none
// ============================================================================
// Module   : d8m_src_if
// Purpose  : Control and D8M parallel pixel bus of the synthetic source.
// Ports    : en          run enable (sampled at frame boundaries)
//            pattern     pattern select (latched at frame start)
//            pixel_vs    frame valid
//            pixel_hs    line valid
//            pixel_d     RAW10 pixel data
//            frame_cnt   completed-frame counter
//            frame_done  one-clock pulse on the last pixel of a frame
//            master = pixel source, slave = controller/consumer
// Revision : 1.0 - initial release
// ============================================================================
interface d8m_src_if;
    import d8m_src_pkg::*;

    logic        en;
    pattern_t    pattern;
    logic        pixel_vs;
    logic        pixel_hs;
    logic [9:0]  pixel_d;
    logic [15:0] frame_cnt;
    logic        frame_done;

    modport master (
        input  en,
        input  pattern,
        output pixel_vs,
        output pixel_hs,
        output pixel_d,
        output frame_cnt,
        output frame_done
    );

    modport slave (
        output en,
        output pattern,
        input  pixel_vs,
        input  pixel_hs,
        input  pixel_d,
        input  frame_cnt,
        input  frame_done
    );
endinterface
`default_nettype wire

// File: rtl/d8m_src_pattern.sv
`default_nettype none
// ============================================================================
// Module   : d8m_src_pattern
// Purpose  : Pattern generator for the D8M pixel source. Latches the pattern
//            select on restart, muxes ramp / Bayer / auxiliary data and
//            registers it one cycle, so the output lines up with the
//            registered HS of the top level.
// Ports    : clk, rst     clock, synchronous active-high reset
//            x, y         pixel index in line, active line index
//            pattern      pattern select, taken on restart
//            frame_cnt    completed-frame count (auxiliary pattern source)
//            advance      active pixel this cycle; output is 0 otherwise
//            restart      frame start: latch pattern, reload aux state
//            d            registered RAW10 pixel
// Options  : D8M_SRC_PRBS_EN - aux pattern is PRBS-10 seeded each frame;
//            otherwise aux pattern is the frame index held for the frame.
// Revision : 1.0 - initial release
// ============================================================================
module d8m_src_pattern
    import d8m_src_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [9:0] x,
    input  wire logic [9:0] y,
    input  pattern_t        pattern,
    input  wire logic [9:0] frame_cnt,
    input  wire logic       advance,
    input  wire logic       restart,
    output logic [9:0]      d
);

    pattern_t   r_pattern;
    logic [9:0] w_aux;
    logic [9:0] w_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= PAT_HRAMP;
        end else if (restart) begin
            r_pattern <= pattern;
        end
    end

`ifdef D8M_SRC_PRBS_EN
    logic [9:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_lfsr <= PRBS_SEED;
        end else if (advance) begin
            r_lfsr <= prbs_next(r_lfsr);
        end
    end

    assign w_aux = r_lfsr;
`else
    // Hold the frame index seen at frame start so the value stays constant
    // even across the edge where the top bumps the counter.
    logic [9:0] r_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (restart) begin
            r_frame <= frame_cnt;
        end
    end

    assign w_aux = r_frame;
`endif

    always_comb begin
        w_pix = '0;
        case (r_pattern)
            PAT_HRAMP: w_pix = x;
            PAT_VRAMP: w_pix = y;
            PAT_BAYER: begin
                case ({y[0], x[0]})
                    2'b00:   w_pix = BAYER_R;
                    2'b11:   w_pix = BAYER_B;
                    default: w_pix = BAYER_G;
                endcase
            end
            PAT_AUX:   w_pix = w_aux;
            default:   w_pix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d <= '0;
        end else begin
            d <= advance ? w_pix : 10'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/d8m_pixel_source.sv
`default_nettype none
// ============================================================================
// Module   : d8m_pixel_source
// Purpose  : Transmit side of the D8M parallel pixel interface. Produces
//            synthetic RAW10 frames (VS/HS/D) with configurable timing for
//            bring-up without a camera. Holds the frame FSM, x/y counters,
//            frame counter and output registers.
// Ports    : clk   pixel clock
//            rst   synchronous reset, active-high
//            bus   d8m_src_if.master (en, pattern, pixel_vs, pixel_hs,
//                  pixel_d, frame_cnt, frame_done)
// Options  : D8M_SRC_PRBS_EN - pattern 3 is PRBS-10 instead of frame index
// Revision : 1.0 - initial release
// ============================================================================
module d8m_pixel_source
    import d8m_src_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_LEAD   = 2,
    parameter int V_ACTIVE = 480,
    parameter int V_GAP    = 20
) (
    input  wire logic clk,
    input  wire logic rst,
    d8m_src_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;

    localparam logic [15:0] X_ACT_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] X_LINE_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] Y_LEAD_LAST = 16'(V_LEAD - 1);
    localparam logic [15:0] Y_ACT_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] Y_GAP_LAST  = 16'(V_GAP - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_first_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic        w_frame_start;
    logic        w_last_pix;
    logic        w_active;

    logic        r_vs;
    logic        r_hs;
    logic        r_done;
    logic [15:0] r_frame_cnt;

    // ------------------------------------------------------------------
    // FSM state and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state. x runs across the whole line (active then blank); in
    // LEAD/GAP it counts line length and y counts blank lines.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x + 16'd1;
        w_y_nxt       = r_y;
        w_frame_start = 1'b0;

        // With no lead lines a frame starts directly on an active line
        if (V_LEAD == 0) begin
            w_first_state = ACTIVE;
        end else begin
            w_first_state = LEAD;
        end

        case (r_state)
            IDLE: begin
                w_x_nxt = '0;
                w_y_nxt = '0;
                if (bus.en) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = w_first_state;
                end
            end
            LEAD: begin
                if (r_x == X_LINE_LAST) begin
                    w_x_nxt = '0;
                    if (r_y == Y_LEAD_LAST) begin
                        w_y_nxt     = '0;
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_y_nxt = r_y + 16'd1;
                    end
                end
            end
            ACTIVE: begin
                if (r_x == X_ACT_LAST) begin
                    w_state_nxt = HBLANK;
                end
            end
            HBLANK: begin
                if (r_x == X_LINE_LAST) begin
                    w_x_nxt = '0;
                    if (r_y == Y_ACT_LAST) begin
                        w_y_nxt     = '0;
                        w_state_nxt = GAP;
                    end else begin
                        w_y_nxt     = r_y + 16'd1;
                        w_state_nxt = ACTIVE;
                    end
                end
            end
            GAP: begin
                if (r_x == X_LINE_LAST) begin
                    w_x_nxt = '0;
                    if (r_y == Y_GAP_LAST) begin
                        w_y_nxt = '0;
                        if (bus.en) begin
                            w_frame_start = 1'b1;
                            w_state_nxt   = w_first_state;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_y_nxt = r_y + 16'd1;
                    end
                end
            end
            default: begin
                w_x_nxt     = '0;
                w_y_nxt     = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_active   = (r_state == ACTIVE);
    assign w_last_pix = w_active && (r_x == X_ACT_LAST) && (r_y == Y_ACT_LAST);

    // ------------------------------------------------------------------
    // Output registers: decoded from the current state, so VS/HS/DONE and
    // the pattern data all trail the FSM by the same single cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs        <= 1'b0;
            r_hs        <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vs   <= (r_state == LEAD) || (r_state == ACTIVE) || (r_state == HBLANK);
            r_hs   <= w_active;
            r_done <= w_last_pix;
            if (w_last_pix) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    d8m_src_pattern u_pattern (
        .clk       (clk),
        .rst       (rst),
        .x         (r_x[9:0]),
        .y         (r_y[9:0]),
        .pattern   (bus.pattern),
        .frame_cnt (r_frame_cnt[9:0]),
        .advance   (w_active),
        .restart   (w_frame_start),
        .d         (bus.pixel_d)
    );

    assign bus.pixel_vs   = r_vs;
    assign bus.pixel_hs   = r_hs;
    assign bus.frame_done = r_done;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_d8m_pixel_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_d8m_pixel_source
// Purpose  : Self-checking bench for d8m_pixel_source with a small frame
//            (8x4 active, 4 blank clocks, 1 lead line, 2 gap lines).
//            Stimulus pushes expected pixels into a scoreboard queue; a
//            monitor pops and compares every HS-high cycle and also checks
//            lead, line, blank and gap lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d8m_pixel_source;
    import d8m_src_pkg::*;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_LEAD   = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_GAP    = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;

    typedef struct packed {
        logic [9:0]  d;
        logic        last;
        logic [15:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    d8m_src_if bus ();

    d8m_pixel_source #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_LEAD   (V_LEAD),
        .V_ACTIVE (V_ACTIVE),
        .V_GAP    (V_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    bit   mon_en    = 1'b0;
    bit   check_gap = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Hand-derived PRBS-10 (x^10+x^7+1): next = {s[0]^s[3], s[9:1]}
    function automatic logic [9:0] ref_prbs(input logic [9:0] s);
        logic [9:0] n;
        n[8:0] = s[9:1];
        n[9]   = s[0] ^ s[3];
        return n;
    endfunction

    task automatic push_frame(input pattern_t pat, input int idx);
        logic [9:0] lfsr;
        exp_t       e;
        lfsr = 10'h3FF;
        for (int yy = 0; yy < V_ACTIVE; yy++) begin
            for (int xx = 0; xx < H_ACTIVE; xx++) begin
                case (pat)
                    PAT_HRAMP: e.d = 10'(xx);
                    PAT_VRAMP: e.d = 10'(yy);
                    PAT_BAYER: begin
                        if ((yy % 2 == 0) && (xx % 2 == 0))      e.d = 10'h3FF;
                        else if ((yy % 2 == 1) && (xx % 2 == 1)) e.d = 10'h000;
                        else                                     e.d = 10'h200;
                    end
                    default: begin
`ifdef D8M_SRC_PRBS_EN
                        e.d  = lfsr;
                        lfsr = ref_prbs(lfsr);
`else
                        e.d = 10'(idx);
`endif
                    end
                endcase
                e.last = (yy == V_ACTIVE - 1) && (xx == H_ACTIVE - 1);
                e.fcnt = e.last ? 16'(idx + 1) : 16'(idx);
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_vs(input logic val, input int budget, input string what);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.pixel_vs === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(what, int'(ok), 1);
    endtask

    // ------------------------------------------------------------------
    // Monitor: scoreboard pop on HS, run-length checks on VS/HS edges
    // ------------------------------------------------------------------
    initial begin
        logic prev_vs, prev_hs, first_line, seen_frame;
        int   vs_hi, vs_lo, hs_cnt, blank;
        exp_t e;
        prev_vs = 0; prev_hs = 0; first_line = 0; seen_frame = 0;
        vs_hi = 0; vs_lo = 0; hs_cnt = 0; blank = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_vs = 0; prev_hs = 0; first_line = 0; seen_frame = 0;
                vs_hi = 0; vs_lo = 0; hs_cnt = 0; blank = 0;
            end else begin
                if (bus.pixel_vs && !prev_vs) begin
                    if (check_gap && seen_frame) check("gap_len", vs_lo, V_GAP * H_TOTAL);
                    vs_hi      = 0;
                    first_line = 1;
                end
                if (!bus.pixel_vs && prev_vs) begin
                    vs_lo      = 0;
                    seen_frame = 1;
                end
                if (bus.pixel_hs && !prev_hs) begin
                    if (first_line) check("lead_len", vs_hi, V_LEAD * H_TOTAL);
                    else            check("hblank_len", blank, H_BLANK);
                    first_line = 0;
                    hs_cnt     = 0;
                end
                if (!bus.pixel_hs && prev_hs) begin
                    check("line_len", hs_cnt, H_ACTIVE);
                    blank = 0;
                end
                if (bus.pixel_hs) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pixel", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("pixel_d", int'(bus.pixel_d), int'(e.d));
                        check("frame_done", int'(bus.frame_done), int'(e.last));
                        check("frame_cnt", int'(bus.frame_cnt), int'(e.fcnt));
                    end
                end else begin
                    check("idle_d_done", int'({bus.frame_done, bus.pixel_d}), 0);
                end
                if (bus.pixel_vs && !bus.pixel_hs) vs_hi++;
                if (!bus.pixel_vs) vs_lo++;
                if (bus.pixel_hs) hs_cnt++;
                else              blank++;
                prev_vs = bus.pixel_vs;
                prev_hs = bus.pixel_hs;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int bad;
        bus.en      = 1'b0;
        bus.pattern = PAT_HRAMP;
        rst         = 1'b1;
        tick(5);
        rst = 1'b0;

        // Reset state
        check("rst_vs",   int'(bus.pixel_vs), 0);
        check("rst_hs",   int'(bus.pixel_hs), 0);
        check("rst_d",    int'(bus.pixel_d), 0);
        check("rst_fcnt", int'(bus.frame_cnt), 0);
        check("rst_done", int'(bus.frame_done), 0);

        // Disabled: outputs stay quiet
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.pixel_vs || bus.pixel_hs || bus.pixel_d != 0 ||
                bus.frame_cnt != 0 || bus.frame_done) bad++;
        end
        check("idle_quiet", bad, 0);

        // Frames 0..2 back to back: ramp, Bayer, vertical ramp.
        // Each pattern change lands mid-frame and must only take effect
        // at the following frame start.
        mon_en      = 1'b1;
        check_gap   = 1'b1;
        bus.pattern = PAT_HRAMP;
        bus.en      = 1'b1;
        push_frame(PAT_HRAMP, 0);
        wait_vs(1'b1, 10, "f0_start");
        bus.pattern = PAT_BAYER;
        push_frame(PAT_BAYER, 1);
        wait_vs(1'b0, 200, "f0_end");
        wait_vs(1'b1, 100, "f1_start");
        bus.pattern = PAT_VRAMP;
        push_frame(PAT_VRAMP, 2);
        wait_vs(1'b0, 200, "f1_end");
        wait_vs(1'b1, 100, "f2_start");
        // Drop enable during active line 2 of frame 2
        tick(V_LEAD * H_TOTAL + 2 * H_TOTAL + 3);
        check("in_line2_hs", int'(bus.pixel_hs), 1);
        bus.en      = 1'b0;
        check_gap   = 1'b0;
        bus.pattern = PAT_AUX;
        wait_vs(1'b0, 200, "f2_end");
        bad = 0;
        for (int i = 0; i < V_GAP * H_TOTAL + 60; i++) begin
            tick(1);
            if (bus.pixel_vs) bad++;
        end
        check("vs_low_after_disable", bad, 0);
        check("queue_drained_a", sb.size(), 0);
        check("fcnt_after_3", int'(bus.frame_cnt), 3);

        // Auxiliary pattern: two frames
        bus.pattern = PAT_AUX;
        bus.en      = 1'b1;
        push_frame(PAT_AUX, 3);
        wait_vs(1'b1, 20, "f3_start");
        tick(3);
        check_gap = 1'b1;
        push_frame(PAT_AUX, 4);
        wait_vs(1'b0, 200, "f3_end");
        wait_vs(1'b1, 100, "f4_start");
        bus.en = 1'b0;
        tick(3);
        check_gap = 1'b0;
        wait_vs(1'b0, 200, "f4_end");
        tick(30);
        check("queue_drained_b", sb.size(), 0);
        check("fcnt_after_5", int'(bus.frame_cnt), 5);

        // Reset in the middle of an active line
        bus.pattern = PAT_HRAMP;
        bus.en      = 1'b1;
        push_frame(PAT_HRAMP, 5);
        wait_vs(1'b1, 20, "f5_start");
        tick(V_LEAD * H_TOTAL + 2);
        check("hs_before_reset", int'(bus.pixel_hs), 1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_vs",   int'(bus.pixel_vs), 0);
        check("midrst_hs",   int'(bus.pixel_hs), 0);
        check("midrst_d",    int'(bus.pixel_d), 0);
        check("midrst_fcnt", int'(bus.frame_cnt), 0);
        check("midrst_done", int'(bus.frame_done), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.frame_done || bus.pixel_hs || bus.pixel_vs) bad++;
        end
        check("rst_hold_quiet", bad, 0);
        bus.en = 1'b0;
        rst    = 1'b0;
        sb.delete();
        tick(2);
        mon_en = 1'b1;

        // One Bayer frame after reset: counter restarts from zero
        bus.pattern = PAT_BAYER;
        bus.en      = 1'b1;
        push_frame(PAT_BAYER, 0);
        wait_vs(1'b1, 20, "f6_start");
        bus.en = 1'b0;
        wait_vs(1'b0, 200, "f6_end");
        tick(30);
        check("queue_drained_c", sb.size(), 0);
        check("fcnt_after_rst", int'(bus.frame_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
